// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Covers funct3 codes, FSM states, lengths and the request latch.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] LEN_B = 8'd1;
  localparam logic [7:0] LEN_H = 8'd2;
  localparam logic [7:0] LEN_W = 8'd4;
  localparam logic [7:0] LEN_D = 8'd8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    RESP
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
  } lsu_req_t;

  function automatic logic is_misal(
    input logic [1:0] sz,
    input logic [2:0] lo
  );
    unique case (sz)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic is_illegal(
    input logic       wr,
    input logic [2:0] f3
  );
    return wr ? f3[2] : (f3 == 3'b111);
  endfunction

  function automatic logic [7:0] len_of(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    return LEN_B;
      2'd1:    return LEN_H;
      2'd2:    return LEN_W;
      default: return LEN_D;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    return 64'h0000_0000_0000_00ff;
      2'd1:    return 64'h0000_0000_0000_ffff;
      2'd2:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the bridge word by the byte offset,
// selects the access width and extends; also flags misalignment.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [2:0]  lo,
  input  logic [63:0] rdata,
  output logic [63:0] data,
  output logic        misal
);

  logic [63:0] raw;

  assign raw   = rdata >> {lo, 3'b000};
  assign misal = is_misal(f3[1:0], lo);

  always_comb begin
    data = '0;
    unique case (f3)
      F3_B:  data = {{56{raw[7]}}, raw[7:0]};
      F3_H:  data = {{48{raw[15]}}, raw[15:0]};
      F3_W:  data = {{32{raw[31]}}, raw[31:0]};
      F3_D:  data = raw;
      F3_BU: data = {56'd0, raw[7:0]};
      F3_HU: data = {48'd0, raw[15:0]};
      F3_WU: data = {32'd0, raw[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store unit between execute and the memory bridge.
// One request in flight; one response per accepted request.
module mem_lsu_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWr,
  input  logic [2:0]  iReqFunct3,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqData,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [63:0] oRespData,
  output logic        oRespErr,
  output logic [63:0] oMemRdAddrLoad,
  input  logic [63:0] iMemRdDataLoad,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrAddr,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrLen
);

  import lsu_pkg::*;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t      state;
  state_t      nstate;
  lsu_req_t    req;
  logic [CW-1:0] cnt;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        idle;
  logic        acc;
  logic        bad;
  logic        st;
  logic        ld;
  logic        rsp;
  logic [2:0]  al_f3;
  logic [2:0]  al_lo;
  logic [63:0] al_data;
  logic        al_misal;

  assign idle = (state == IDLE);
  assign ld   = (state == LOAD);
  assign st   = (state == STORE);
  assign rsp  = (state == RESP);
  assign acc  = iReqValid & idle;

  // Aligner sees the incoming request while idle, the latched one after.
  assign al_f3 = idle ? iReqFunct3    : req.f3;
  assign al_lo = idle ? iReqAddr[2:0] : req.addr[2:0];
  assign bad   = al_misal | is_illegal(iReqWr, iReqFunct3);

  lsu_load_align u_align (
    .f3    (al_f3),
    .lo    (al_lo),
    .rdata (iMemRdDataLoad),
    .data  (al_data),
    .misal (al_misal)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (bad)         nstate = RESP;
          else if (iReqWr) nstate = STORE;
          else             nstate = LOAD;
        end
      end
      LOAD:  if (cnt == '0) nstate = RESP;
      STORE: nstate = RESP;
      RESP:  if (iRespReady) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      req     <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (acc) begin
        req     <= '{wr: iReqWr, f3: iReqFunct3,
                     addr: iReqAddr, data: iReqData};
        cnt     <= CW'(MEM_LAT - 1);
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (ld) begin
        if (cnt == '0) rdata_q <= al_data;
        else           cnt     <= cnt - 1'b1;
      end
    end
  end

  // Outputs gated by state so an async reset clears them at once.
  assign oReqReady      = idle;
  assign oRespValid     = rsp;
  assign oRespData      = rsp ? rdata_q : '0;
  assign oRespErr       = rsp & err_q;
  assign oMemRdAddrLoad = ld ? {req.addr[63:3], 3'b000} : '0;
  assign oMemWrEn       = st;
  assign oMemWrAddr     = st ? req.addr : '0;
  assign oMemWrData     = st ? (req.data & mask_of(req.f3[1:0])) : '0;
  assign oMemWrLen      = st ? len_of(req.f3[1:0]) : '0;

endmodule
